// File: rtl/bpsk_tx_if.sv
// bpsk_tx_if: bit-stream handshake plus modulated sample output of the BPSK
// transmitter, bundled so the source and the sample consumer share one
// connection.
//
// Signals:
//   bit_valid  source has a data bit on bit_in
//   bit_in     data bit (0 -> +carrier, 1 -> -carrier)
//   bit_ready  transmitter accepts the bit this cycle (transfer = valid & ready)
//   dout       signed modulated sample, OUT_W bits two's complement
//   dout_valid dout carries a live sample
//
// Modports:
//   master  bit source / sample sink (testbench or upstream logic)
//   slave   the transmitter itself
interface bpsk_tx_if #(
    parameter int OUT_W = 8
);
    logic                    bit_valid;
    logic                    bit_in;
    logic                    bit_ready;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;

    modport master (
        output bit_valid,
        output bit_in,
        input  bit_ready,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  bit_valid,
        input  bit_in,
        output bit_ready,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/bpsk_tx.sv
// bpsk_tx: BPSK carrier modulator. Accepts data bits over a valid/ready
// handshake, holds each bit for SAMPLES_PER_SYM clocks and multiplies it onto
// a sine carrier produced by a phase-accumulator NCO with a quarter-wave
// sine table. Output samples are signed OUT_W-bit values.
//
// Ports:
//   clk        sole clock
//   rst        synchronous reset, active-high
//   enable     level; 1 = start or continue transmitting
//   freq_we    write strobe for the tuning word
//   freq_data  new tuning word (PHASE_W bits)
//   bus        bpsk_tx_if.slave: bit_valid/bit_in/bit_ready, dout/dout_valid
//   busy       state machine is not idle
//   underrun   sticky; a symbol boundary arrived with no bit available
//
// Optional feature macro: DIFF_ENC_EN
//   defined   -> differential encoding, d_k = bit_k ^ d_{k-1}, d = 0 at start,
//                underrun repeats d_{k-1}
//   undefined -> transmitted symbol is the data bit itself
module bpsk_tx #(
    parameter int                 PHASE_W         = 32,
    parameter logic [PHASE_W-1:0] FREQ_INIT       = 32'h2000_0000,
    parameter logic [PHASE_W-1:0] PHASE_INIT      = 32'h0000_0000,
    parameter int                 SAMPLES_PER_SYM = 64,
    parameter int                 OUT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               freq_we,
    input  logic [PHASE_W-1:0] freq_data,
    bpsk_tx_if.slave           bus,
    output logic               busy,
    output logic               underrun
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [PHASE_W-1:0]       freq;
    logic [PHASE_W-1:0]       phase_acc;
    logic [15:0]              sym_cnt;
    logic                     symbol;
    logic                     next_symbol;
    logic                     transfer;
    logic                     last_sample;
    logic [7:0]               table_idx;
    logic [6:0]               quarter_idx;
    logic signed [7:0]        quarter_mag;
    logic signed [7:0]        sine_val;
    logic signed [7:0]        carrier_q;
    logic signed [OUT_W-1:0]  carrier_ext;
    logic                     sym_q;
    logic                     run_q;

    // Quarter-wave table: round(127*sin(pi/2*k/64)) for k = 0..64.
    function automatic logic [6:0] quarter_sine(input logic [6:0] k);
        logic [6:0] v;
        case (k)
            7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
            7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
            7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
            7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
            7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
            7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
            7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
            7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
            7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
            7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
            7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
            7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
            7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
            7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
            7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
            7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
            7'd64: v = 7'd127;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    assign transfer    = bus.bit_valid & bus.bit_ready;
    assign last_sample = (sym_cnt == 16'(SAMPLES_PER_SYM - 1));

`ifdef DIFF_ENC_EN
    // The symbol register holds d_{k-1}; START treats it as 0 so the first
    // transmitted symbol equals the first bit.
    assign next_symbol = bus.bit_in ^ ((state == START) ? 1'b0 : symbol);
`else
    assign next_symbol = bus.bit_in;
`endif

    // Quadrants 1 and 3 read the table mirrored; quadrants 2 and 3 negate.
    assign table_idx   = phase_acc[PHASE_W-1 -: 8];
    assign quarter_idx = table_idx[6] ? (7'd64 - {1'b0, table_idx[5:0]})
                                      : {1'b0, table_idx[5:0]};
    assign quarter_mag = {1'b0, quarter_sine(quarter_idx)};
    assign sine_val    = table_idx[7] ? -quarter_mag : quarter_mag;
    assign carrier_ext = OUT_W'(carrier_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a running symbol always completes before IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (enable) state_next = START;
            START: begin
                if (transfer) begin
                    state_next = RUN;
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            RUN:   if (last_sample && !enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; in RUN a bit is only taken on the last sample of a symbol.
    always_comb begin
        bus.bit_ready = 1'b0;
        busy          = (state != IDLE);
        case (state)
            START:   bus.bit_ready = 1'b1;
            RUN:     bus.bit_ready = last_sample & enable;
            default: bus.bit_ready = 1'b0;
        endcase
    end

    // NCO, symbol counter, symbol latch and sticky underrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq      <= FREQ_INIT;
            phase_acc <= PHASE_INIT;
            sym_cnt   <= 16'd0;
            symbol    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (freq_we) begin
                freq <= freq_data;
            end
            case (state)
                START: begin
                    if (transfer) begin
                        phase_acc <= PHASE_INIT;
                        sym_cnt   <= 16'd0;
                        symbol    <= next_symbol;
                    end
                end
                RUN: begin
                    phase_acc <= phase_acc + freq;
                    if (last_sample) begin
                        sym_cnt <= 16'd0;
                        if (transfer) begin
                            symbol <= next_symbol;
                        end else if (enable) begin
                            underrun <= 1'b1;
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-stage output pipeline: table register, then sign/output register.
    // The symbol travels alongside so polarity stays aligned with phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q      <= 8'sd0;
            sym_q          <= 1'b0;
            run_q          <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            run_q          <= (state == RUN);
            carrier_q      <= (state == RUN) ? sine_val : 8'sd0;
            sym_q          <= symbol;
            bus.dout_valid <= run_q;
            if (run_q) begin
                bus.dout <= sym_q ? -carrier_ext : carrier_ext;
            end else begin
                bus.dout <= '0;
            end
        end
    end

endmodule

// File: doc/bpsk_tx.md
Name: bpsk_tx

Overview:
BPSK carrier modulator. It is the transmit-side counterpart of the Costas-loop receiver. It takes a bit stream through a valid/ready handshake, holds each bit for SAMPLES_PER_SYM clocks, and multiplies it onto an NCO-generated sine carrier. The output is signed 8-bit samples that feed the receiver's 8-bit din directly, for loopback and channel tests.

Parameters:
PHASE_W, 32, phase accumulator / tuning word width
FREQ_INIT, 32'h2000_0000, tuning word after reset (fs/8 carrier)
PHASE_INIT, 32'h0000_0000, accumulator value loaded at each transmission start
SAMPLES_PER_SYM, 64, clocks per symbol; legal range 2..65535
OUT_W, 8, output sample width (two's complement)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous reset, active-high
enable  in  1  level; 1 = start or continue transmitting
freq_we  in  1  write strobe for tuning word
freq_data  in  PHASE_W  new tuning word
bit_valid  in  1  source has a bit
bit_in  in  1  data bit (0 -> +carrier, 1 -> -carrier)
bit_ready  out  1  block accepts bit this cycle (transfer = valid & ready)
dout  out  OUT_W  modulated sample
dout_valid  out  1  dout is a live sample
busy  out  1  state != IDLE
underrun  out  1  sticky; a symbol boundary arrived with no bit available

Behaviour:
- Reset values (synchronous, active-high):
  - dout=0, dout_valid=0, bit_ready=0, busy=0, underrun=0.
  - freq reg=FREQ_INIT, phase_acc=PHASE_INIT, sym_cnt=0, state=IDLE.
- freq_we:
  - Accepted in any state; freq reg updates at the next edge.
  - The accumulator uses the new word from the following cycle.
- State machine:
  - IDLE: accumulator frozen, dout pipeline forced to 0. enable=1 -> START.
  - START: bit_ready=1.
    - On transfer: latch symbol, phase_acc<=PHASE_INIT, sym_cnt<=0, go to RUN.
    - enable=0 while waiting -> IDLE.
  - RUN: each cycle phase_acc += freq (mod 2^PHASE_W) and sym_cnt++.
    - bit_ready=1 only when sym_cnt==SAMPLES_PER_SYM-1 and enable=1.
    - At that last sample, sym_cnt wraps to 0.
    - Transfer -> next symbol = bit_in.
    - No transfer and enable=1 -> repeat previous symbol and set underrun (held until rst).
    - enable=0 -> go to IDLE after the last sample of the current symbol. Symbols are never truncated.
  - rst mid-RUN: immediate return to reset values; partial symbol discarded.
- Carrier:
  - Table index = phase_acc[PHASE_W-1:PHASE_W-8].
  - Sample = round(127*sin(2*pi*idx/256)); range -127..+127, never -128.
  - Quarter-wave or full table is an implementation choice; results must be bit-identical.
- Modulation: dout = symbol ? -carrier : carrier. Negation cannot overflow.
- Latency:
  - Pipeline: accumulator -> table register -> sign/output register.
  - dout at cycle n+2 corresponds to phase_acc value at cycle n.
  - dout_valid mirrors the RUN state delayed by 2 cycles.
  - After RUN->IDLE, the two in-flight samples are still emitted valid, then dout=0.
- Symbol timing:
  - A symbol change takes effect on the first sample of the new symbol (sym_cnt==0).
  - It appears on dout 2 cycles later.

Optional Feature:
DIFF_ENC_EN.
- Defined: differential encoding. Transmitted symbol d_k = bit_k XOR d_{k-1}. d is cleared to 0 at START, so the first symbol equals the first bit. On underrun, d_k = d_{k-1}, i.e. the phase does not flip. This resolves the receiver's 180-degree ambiguity.
- Undefined: symbol = bit_in directly; no extra register.

Test Plan:
1. Reset release, enable=1, bit 0 at START, FREQ_INIT -> dout_valid rises 2 cycles after entering RUN; dout repeats 0,90,127,90,0,-90,-127,-90.
2. Bits 0,1 with SAMPLES_PER_SYM=8 -> first 8 valid samples as in test 1, next 8 samples negated (0,-90,-127,-90,0,90,127,90); bit_ready pulses once per 8 clocks.
3. bit_valid held 0 at a boundary -> underrun=1 and stays 1; previous symbol repeats; next valid bit is accepted only at the following boundary.
4. freq_we with 0x4000_0000 mid-RUN -> from 3 cycles later dout repeats 0,127,0,-127; phase is continuous (no reset of phase_acc).
5. enable dropped at sym_cnt=3 -> current symbol completes all SAMPLES_PER_SYM samples, busy falls, dout_valid falls 2 cycles later, dout=0; rst asserted mid-symbol instead -> all outputs 0 on the next clock.
6. DIFF_ENC_EN defined, bits 1,1,0,1 -> transmitted polarity sequence -,+,+,- (d=1,0,0,1).
